// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared encodings for the pipeline hazard unit
package hazard_pkg;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'b00,
      DIV_BUSY = 2'b01,
      DIV_DONE = 2'b10
   } divState_t;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   // M-stage result is younger than W-stage result, so it wins
   function automatic logic [1:0] fwdSel(input logic hitM, input logic hitW);
      if (hitM)
         return FWD_MEM;
      else if (hitW)
         return FWD_WB;
      else
         return FWD_RF;
   endfunction

endpackage

// File: rtl/hazard_unit_div_seq.sv
// rtl/hazard_unit_div_seq.sv - divide sequencer holding E for DIV_CYCLES cycles
module div_seq
   import hazard_pkg::*;
#(
   parameter int DIV_CYCLES = 32
) (
   input  logic clk,
   input  logic rst,
   input  logic div_startE,
   output logic divstall,
   output logic div_busy,
   output logic div_done
);

   localparam int CNT_W = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 2);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   divState_t        state;
   divState_t        nextState;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] nextCnt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= DIV_IDLE;
         cnt   <= '0;
      end else begin
         state <= nextState;
         cnt   <= nextCnt;
      end
   end

   // cnt holds the number of BUSY cycles still to run, so the IDLE cycle plus
   // DIV_CYCLES-2 BUSY cycles give DIV_CYCLES-1 stall cycles before DONE
   always_comb begin
      nextState = state;
      nextCnt   = cnt;
      divstall  = 1'b0;
      div_busy  = 1'b0;
      div_done  = 1'b0;
      case (state)
         DIV_IDLE: begin
            if (div_startE) begin
               divstall = 1'b1;
               nextCnt  = CNT_LOAD;
               nextState = (DIV_CYCLES > 2) ? DIV_BUSY : DIV_DONE;
            end
         end
         DIV_BUSY: begin
            divstall = 1'b1;
            div_busy = 1'b1;
            if (cnt <= CNT_ONE) begin
               nextCnt   = '0;
               nextState = DIV_DONE;
            end else begin
               nextCnt = cnt - CNT_ONE;
            end
         end
         DIV_DONE: begin
            div_done  = 1'b1;
            nextState = DIV_IDLE;
         end
         default: begin
            nextState = DIV_IDLE;
            nextCnt   = '0;
         end
      endcase
   end

endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - forwarding selects and stall/flush strobes for the 5-stage core
module hazard_unit
   import hazard_pkg::*;
#(
   parameter int REG_W      = 5,
   parameter int DIV_CYCLES = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [REG_W-1:0] rsD,
   input  logic [REG_W-1:0] rtD,
   input  logic             branchD,
   input  logic [REG_W-1:0] rsE,
   input  logic [REG_W-1:0] rtE,
   input  logic [REG_W-1:0] writeregE,
   input  logic             regwriteE,
   input  logic             memtoregE,
   input  logic             div_startE,
   input  logic [REG_W-1:0] writeregM,
   input  logic             regwriteM,
   input  logic             memtoregM,
   input  logic [REG_W-1:0] writeregW,
   input  logic             regwriteW,
   output logic             forwardAD,
   output logic             forwardBD,
   output logic [1:0]       forwardAE,
   output logic [1:0]       forwardBE,
   output logic             stallF,
   output logic             stallD,
   output logic             stallE,
   output logic             flushE,
   output logic             flushM,
   output logic             div_busy,
   output logic             div_done
);

   // $0 is hardwired, so it never produces a dependency
   function automatic logic regHit(input logic [REG_W-1:0] a, input logic [REG_W-1:0] b);
      return (a == b) && (a != '0);
   endfunction

   logic divstall;
   logic seqBusy;
   logic seqDone;
   logic lwstall;
   logic branchstall;
   logic hazStall;

   div_seq #(.DIV_CYCLES(DIV_CYCLES)) uDivSeq (
      .clk        (clk),
      .rst        (rst),
      .div_startE (div_startE),
      .divstall   (divstall),
      .div_busy   (seqBusy),
      .div_done   (seqDone)
   );

   always_comb begin
      lwstall = memtoregE && (regHit(rtE, rsD) || regHit(rtE, rtD));
      branchstall = branchD &&
         ((regwriteE && (regHit(writeregE, rsD) || regHit(writeregE, rtD))) ||
          (memtoregM && (regHit(writeregM, rsD) || regHit(writeregM, rtD))));
      hazStall = lwstall || branchstall;
   end

   // reset forces bubbles into E and M and silences everything else
   always_comb begin
      forwardAD = regwriteM && regHit(writeregM, rsD);
      forwardBD = regwriteM && regHit(writeregM, rtD);
      forwardAE = fwdSel(regwriteM && regHit(writeregM, rsE),
                         regwriteW && regHit(writeregW, rsE));
      forwardBE = fwdSel(regwriteM && regHit(writeregM, rtE),
                         regwriteW && regHit(writeregW, rtE));
      stallF    = hazStall || divstall;
      stallD    = hazStall || divstall;
      stallE    = divstall;
      flushE    = hazStall && !divstall;
      flushM    = divstall;
      div_busy  = seqBusy;
      div_done  = seqDone;
      if (!rst) begin
         forwardAD = 1'b0;
         forwardBD = 1'b0;
         forwardAE = FWD_RF;
         forwardBE = FWD_RF;
         stallF    = 1'b0;
         stallD    = 1'b0;
         stallE    = 1'b0;
         flushE    = 1'b1;
         flushM    = 1'b1;
         div_busy  = 1'b0;
         div_done  = 1'b0;
      end
   end

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - scoreboard bench for hazard_unit with a 4-cycle divide
module tb_hazard_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
   logic       branchD, regwriteE, memtoregE, div_startE;
   logic       regwriteM, memtoregM, regwriteW;
   logic       forwardAD, forwardBD;
   logic [1:0] forwardAE, forwardBE;
   logic       stallF, stallD, stallE, flushE, flushM, div_busy, div_done;

   logic [12:0] got;
   logic [12:0] exp;
   logic [12:0] sbq[$];
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   hazard_unit #(.REG_W(5), .DIV_CYCLES(4)) dut (
      .clk(clk), .rst(rst),
      .rsD(rsD), .rtD(rtD), .branchD(branchD),
      .rsE(rsE), .rtE(rtE), .writeregE(writeregE),
      .regwriteE(regwriteE), .memtoregE(memtoregE), .div_startE(div_startE),
      .writeregM(writeregM), .regwriteM(regwriteM), .memtoregM(memtoregM),
      .writeregW(writeregW), .regwriteW(regwriteW),
      .forwardAD(forwardAD), .forwardBD(forwardBD),
      .forwardAE(forwardAE), .forwardBE(forwardBE),
      .stallF(stallF), .stallD(stallD), .stallE(stallE),
      .flushE(flushE), .flushM(flushM),
      .div_busy(div_busy), .div_done(div_done)
   );

   assign got = {forwardAD, forwardBD, forwardAE, forwardBE,
                 stallF, stallD, stallE, flushE, flushM, div_busy, div_done};

   function automatic logic [12:0] mk(input logic fAD, input logic fBD,
                                      input logic [1:0] fAE, input logic [1:0] fBE,
                                      input logic sF, input logic sD, input logic sE,
                                      input logic fE, input logic fM,
                                      input logic busy, input logic done);
      return {fAD, fBD, fAE, fBE, sF, sD, sE, fE, fM, busy, done};
   endfunction

   task automatic clear_inputs();
      rst = 1'b1;
      rsD = 0; rtD = 0; rsE = 0; rtE = 0;
      writeregE = 0; writeregM = 0; writeregW = 0;
      branchD = 0; regwriteE = 0; memtoregE = 0; div_startE = 0;
      regwriteM = 0; memtoregM = 0; regwriteW = 0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      next_cycle();
      clear_inputs();
      rst = 1'b0;
      div_startE = 1'b1;
      regwriteM = 1'b1; writeregM = 5'd3; rsE = 5'd3;
      sbq.push_back(mk(0, 0, 2'b00, 2'b00, 0, 0, 0, 1, 1, 0, 0));
      @(negedge clk);
      exp = sbq.pop_front(); checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL reset got=%b exp=%b", got, exp);
      end
      next_cycle();
      clear_inputs();
      sbq.push_back(mk(0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      exp = sbq.pop_front(); checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL reset_release got=%b exp=%b", got, exp);
      end
   endtask

   task automatic test_forward_e();
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         clear_inputs();
         rsE = 5'd3; rtE = 5'd3;
         case (i)
            0: begin regwriteM = 1; writeregM = 5'd3;
                  sbq.push_back(mk(0, 0, 2'b10, 2'b10, 0, 0, 0, 0, 0, 0, 0)); end
            1: begin regwriteM = 1; writeregM = 5'd3; regwriteW = 1; writeregW = 5'd3;
                  sbq.push_back(mk(0, 0, 2'b10, 2'b10, 0, 0, 0, 0, 0, 0, 0)); end
            default: begin regwriteW = 1; writeregW = 5'd3; rtE = 5'd9;
                  sbq.push_back(mk(0, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0)); end
         endcase
         @(negedge clk);
         exp = sbq.pop_front(); checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL forward_e[%0d] got=%b exp=%b", i, got, exp);
         end
      end
   endtask

   task automatic test_lwstall();
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         clear_inputs();
         case (i)
            0: begin memtoregE = 1; regwriteE = 1; writeregE = 5'd5; rtE = 5'd5; rsD = 5'd5;
                  sbq.push_back(mk(0, 0, 2'b00, 2'b00, 1, 1, 0, 1, 0, 0, 0)); end
            1: begin memtoregM = 1; regwriteM = 1; writeregM = 5'd5; rsD = 5'd5;
                  sbq.push_back(mk(1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0)); end
            default: begin regwriteW = 1; writeregW = 5'd5; rsE = 5'd5;
                  sbq.push_back(mk(0, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0)); end
         endcase
         @(negedge clk);
         exp = sbq.pop_front(); checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL lwstall[%0d] got=%b exp=%b", i, got, exp);
         end
      end
   endtask

   task automatic test_branch();
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         clear_inputs();
         branchD = 1; rsD = 5'd4;
         case (i)
            0: begin regwriteE = 1; writeregE = 5'd4;
                  sbq.push_back(mk(0, 0, 2'b00, 2'b00, 1, 1, 0, 1, 0, 0, 0)); end
            1: begin regwriteM = 1; writeregM = 5'd4;
                  sbq.push_back(mk(1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0)); end
            default: begin rsD = 5'd8; rtD = 5'd4; regwriteM = 1; memtoregM = 1; writeregM = 5'd4;
                  sbq.push_back(mk(0, 1, 2'b00, 2'b00, 1, 1, 0, 1, 0, 0, 0)); end
         endcase
         @(negedge clk);
         exp = sbq.pop_front(); checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL branch[%0d] got=%b exp=%b", i, got, exp);
         end
      end
   endtask

   task automatic test_reg_zero();
      next_cycle();
      clear_inputs();
      regwriteM = 1; writeregM = 0; rsE = 0; rtE = 0;
      memtoregE = 1; regwriteW = 1; writeregW = 0;
      branchD = 1; regwriteE = 1; writeregE = 0;
      sbq.push_back(mk(0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      exp = sbq.pop_front(); checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL reg_zero got=%b exp=%b", got, exp);
      end
   endtask

   task automatic test_back_to_back_div();
      // a branch hazard sits in D through the first divide and resurfaces at DONE
      logic [12:0] steps [9];
      steps[0] = mk(0, 0, 2'b00, 2'b00, 1, 1, 1, 0, 1, 0, 0);
      steps[1] = mk(0, 0, 2'b00, 2'b00, 1, 1, 1, 0, 1, 1, 0);
      steps[2] = mk(0, 0, 2'b00, 2'b00, 1, 1, 1, 0, 1, 1, 0);
      steps[3] = mk(0, 0, 2'b00, 2'b00, 1, 1, 0, 1, 0, 0, 1);
      steps[4] = mk(0, 0, 2'b00, 2'b00, 1, 1, 1, 0, 1, 0, 0);
      steps[5] = mk(0, 0, 2'b00, 2'b00, 1, 1, 1, 0, 1, 1, 0);
      steps[6] = mk(0, 0, 2'b00, 2'b00, 1, 1, 1, 0, 1, 1, 0);
      steps[7] = mk(0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1);
      steps[8] = mk(0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 9; i++) begin
         next_cycle();
         clear_inputs();
         div_startE = (i < 6);
         if (i < 4) begin
            branchD = 1; rsD = 5'd7; regwriteE = 1; writeregE = 5'd7;
         end
         sbq.push_back(steps[i]);
         @(negedge clk);
         exp = sbq.pop_front(); checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL div_seq[%0d] got=%b exp=%b", i, got, exp);
         end
      end
   endtask

   task automatic test_reset_mid_div();
      logic [12:0] steps [5];
      steps[0] = mk(0, 0, 2'b00, 2'b00, 1, 1, 1, 0, 1, 0, 0);
      steps[1] = mk(0, 0, 2'b00, 2'b00, 1, 1, 1, 0, 1, 1, 0);
      steps[2] = mk(0, 0, 2'b00, 2'b00, 0, 0, 0, 1, 1, 0, 0);
      steps[3] = mk(0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);
      steps[4] = mk(0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         next_cycle();
         clear_inputs();
         div_startE = (i < 3);
         rst = (i != 2);
         sbq.push_back(steps[i]);
         @(negedge clk);
         exp = sbq.pop_front(); checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL reset_mid_div[%0d] got=%b exp=%b", i, got, exp);
         end
      end
   endtask

   initial begin
      clear_inputs();
      rst = 1'b0;
      test_reset();
      test_forward_e();
      test_lwstall();
      test_branch();
      test_reg_zero();
      test_back_to_back_div();
      test_reset_mid_div();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
